ikaopm_core: RTL and testbench
==============================

Name: ikaopm_core

Overview:
- Compact YM2151-compatible (OPM) sound core; clocked by a fast emulation clock, with a phiM clock-enable input.
- Provides the OPM bus interface, register file, timers A/B with IRQ, and CT1/CT2 outputs.
- Synthesis is simplified: 8 key-on square-wave channels summed into a stereo mix.
- Output goes out as a YM3012 serial float stream (SO/SH1/SH2), plus parallel emulation outputs for the rest of the audio path.

Parameters:
- FULLY_SYNCHRONOUS, 1, bus inputs (CS_n/RD_n/WR_n/A0/D) pass through a 2-stage i_EMUCLK synchroniser; 0 = 1 stage.
- FAST_RESET, 1, IC_n clears the register file immediately.
  - With 0, the register file is instead cleared by a sweep after IC_n release: one address per phi1 cycle, 256 cycles, busy=1, writes ignored.

Ports:
- i_EMUCLK  in  1  sole clock
- i_IC_n  in  1  reset, asynchronous, active-low
- i_phiM_PCEN_n  in  1  phiM clock enable, active-low, sampled on i_EMUCLK
- o_phi1  out  1  phiM/2
- i_CS_n, i_RD_n, i_WR_n, i_A0  in  1 each  bus strobes/address
- i_D  in  8  bus write data
- o_D  out  8  status read data
- o_D_OE  out  1  data output enable
- o_CT1, o_CT2  out  1 each  reg 0x1B bit6, bit7
- o_IRQ_n  out  1  timer interrupt, active-low
- o_SH1, o_SH2  out  1 each  right/left sample-hold strobes
- o_SO  out  1  serial DAC data
- o_EMU_R_SAMPLE, o_EMU_L_SAMPLE  out  1 each  one-EMUCLK pulse: new sample valid
- o_EMU_R_EX, o_EMU_L_EX  out  16 signed  DAC-reconstructed (float-decoded) value
- o_EMU_R, o_EMU_L  out  16 signed  linear saturated mix

Behaviour:
- Reset (IC_n=0, async): all state cleared.
  - phi1=0, SO=SH1=SH2=0, IRQ_n=1, D_OE=0, o_D=0, CT1=CT2=0, all EMU outputs 0.
  - Slot counter=0; phases, key-on flags, timers and flags cleared.
- Clocking:
  - phi1 toggles on each i_EMUCLK edge with phiM_PCEN_n=0.
  - A 5-bit slot counter increments on each phi1 rise; 32 slots = 1 sample period.
- Write:
  - Detect falling edge of (CS_n|WR_n) after the synchroniser.
  - A0=0 latches i_D as the address; A0=1 writes i_D to reg[address].
  - A data write sets busy for 32 phi1 cycles; writes during busy are still accepted.
- Read: CS_n=0 and RD_n=0 gives D_OE=1, o_D={busy,5'b0,flagB,flagA}; otherwise D_OE=0.
- Registers used:
  - 0x08 key-on: ch=D[2:0], key on if D[6:3]≠0, else off.
  - 0x10/0x11 NA (10-bit: 0x10 = high 8 bits, 0x11[1:0] = low 2 bits).
  - 0x12 NB.
  - 0x14: bit0 runA, bit1 runB, bit2 irqenA, bit3 irqenB; bit4/bit5 clear flagA/flagB (write-1 pulse).
  - 0x1B CT bits.
  - 0x20+ch: bit7 R enable, bit6 L enable.
  - 0x28+ch KC[6:0].
  - 0x60+ch TL[6:0].
  - All other addresses stored, unused.
- Timers:
  - Timer A counts once per sample from NA to 1023; on overflow it sets flagA (if irqenA) and reloads.
  - Timer B counts once per 16 samples from NB to 255; overflow behaves likewise for flagB.
  - Both load on a run 0→1 transition.
  - o_IRQ_n = ~(flagA|flagB).
- Synthesis, once per sample at slot 31, for each channel:
  - Keyed on: phase += ({4'b0001,KC[3:0]} << KC[6:4]) mod 2^16.
  - Keyed off: phase=0, value=0.
  - amp = 0x1FFF >> TL[6:3]; value = phase[15] ? -amp : +amp.
  - R sum = Σ value over channels with bit7 set; L sum likewise with bit6.
  - Saturate to [-32768, 32767] → o_EMU_R/L.
- Float encode per channel sample s:
  - Choose the largest e in 7..2 with s[e+8] ≠ s[e+7]; else e=1.
  - Mantissa field = s[e+8:e-1], with its top bit inverted (1 = positive).
  - 13-bit frame = {e[2:0], ~s[e+8], s[e+7:e-1]}.
  - EX decode: positive = m[8:0] << (e-1); negative = -((~m[8:0]) << (e-1)).
- Serial output (changes on phi1 fall, sampled on phi1 rise):
  - Slots 0–15 carry R, slots 16–31 carry L.
  - Within a half, sub-slots 0–12 send frame bits LSB first; sub-slots 13–15 send 0.
  - SH1 (R) / SH2 (L) is high at sub-slots 3–12 and falls at sub-slot 13.
  - Frames use the sample computed at the previous slot 31.
- EMU_*_SAMPLE pulse one i_EMUCLK at the phi1 rise where slot 31 ends, together with the updated EMU values.
- Reset mid-frame: outputs go to reset values immediately; restart from slot 0 after release.
- Key-on with all RL=0: mix is 0; the frame encodes 0 as e=1, m=0x000, sign bit=1.

Test Plan:
- Reset, then 100 phiM enables → o_phi1 period = 2 enables; SO/SH low until first frame; IRQ_n=1; o_D status=0x00.
- Write 0x28=0x42, 0x60=21, 0x20=0xFC, 0x08=0x18 (ch0 on):
  - o_EMU_R = o_EMU_L = +2047; frame e=3, m=0x1FF, EX = 2044.
  - Sign flips after 114 samples (phase inc = 288).
- Same setup, then write 0x08=0x00 → next sample R = L = 0, phase reset.
- Write 0x20=0x80 only (R-only) → o_EMU_L=0, o_EMU_R=+2047.
- Write NA=1023 (0x10=0xFF, 0x11=0x03), 0x14=0x05:
  - flagA set after 1 sample; IRQ_n=0; status=0x01.
  - Write 0x14=0x10 clears flagA; IRQ_n=1.
- Write 0x1B=0xC0 → CT1=1, CT2=1.
- Status read immediately after a data write → bit7 busy=1, cleared 32 phi1 later.

Source files
------------

// File: rtl/ikaopm_core.sv
// ikaopm_core: compact YM2151-compatible sound core with bus interface, register file and timers.
// Eight key-on square-wave channels feed a stereo mix, output as a YM3012-style serial float stream.
module ikaopm_core #(
    parameter int FULLY_SYNCHRONOUS = 1,
    parameter int FAST_RESET        = 1
) (
    input  logic               i_EMUCLK,
    input  logic               i_IC_n,
    input  logic               i_phiM_PCEN_n,
    output logic               o_phi1,
    input  logic               i_CS_n,
    input  logic               i_RD_n,
    input  logic               i_WR_n,
    input  logic               i_A0,
    input  logic [7:0]         i_D,
    output logic [7:0]         o_D,
    output logic               o_D_OE,
    output logic               o_CT1,
    output logic               o_CT2,
    output logic               o_IRQ_n,
    output logic               o_SH1,
    output logic               o_SH2,
    output logic               o_SO,
    output logic               o_EMU_R_SAMPLE,
    output logic               o_EMU_L_SAMPLE,
    output logic signed [15:0] o_EMU_R_EX,
    output logic signed [15:0] o_EMU_L_EX,
    output logic signed [15:0] o_EMU_R,
    output logic signed [15:0] o_EMU_L
);

    // Frame is {exponent[2:0], sign (1 = positive), mantissa[8:0]}.
    function automatic logic [12:0] float_enc(input logic [15:0] s);
        logic [2:0] e;
        logic [9:0] m;
        e = 3'd1;
        for (int unsigned i = 2; i <= 7; i++)
            if (s[i+8] != s[i+7]) e = 3'(i);
        m = 10'(s >> (e - 3'd1));
        return {e, ~m[9], m[8:0]};
    endfunction

    function automatic logic signed [15:0] float_dec(input logic [12:0] f);
        logic [15:0] mag;
        if (f[9]) mag = {7'd0,  f[8:0]} << (f[12:10] - 3'd1);
        else      mag = {7'd0, ~f[8:0]} << (f[12:10] - 3'd1);
        if (f[9]) return signed'(mag);
        else      return -signed'(mag);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)       return 16'sh7FFF;
        else if (v < -19'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    typedef enum logic {ST_SWEEP, ST_RUN} rst_state_t;

    logic              phi1, phi1_rise, phi1_fall;
    logic [4:0]        slot;
    logic              sample_tick;
    logic [11:0]       bus_raw, sync1, sync2, bus_s;
    logic              cs_s, rd_s, wr_s, a0_s;
    logic [7:0]        d_s;
    rst_state_t        state, state_nx;
    logic [7:0]        sweep_addr;
    logic              wstb_q, wr_fall, data_wr, addr_wr;
    logic [7:0]        regs [256];
    logic              reg_we;
    logic [7:0]        reg_wa, reg_wd;
    logic [7:0]        addr_q;
    logic [5:0]        busy_cnt;
    logic              busy;
    logic [7:0]        keyon;
    logic [15:0]       phase    [8];
    logic [15:0]       phase_nx [8];
    logic [6:0]        kc;
    logic [3:0]        tl;
    logic [1:0]        rl;
    logic [15:0]       inc;
    logic [12:0]       amp;
    logic signed [14:0] val;
    logic signed [18:0] sum_r, sum_l;
    logic signed [15:0] mix_r, mix_l;
    logic [12:0]       enc_r, enc_l, frame_r, frame_l, cur_frame;
    logic              sh_win;
    logic [9:0]        na, cnt_a;
    logic [7:0]        nb, cnt_b;
    logic [3:0]        presc_b;
    logic [3:0]        tctrl;
    logic              flag_a, flag_b;
    logic [1:0]        ct;
    logic [7:0]        status;

    assign phi1_rise   = ~i_phiM_PCEN_n & ~phi1;
    assign phi1_fall   = ~i_phiM_PCEN_n &  phi1;
    assign sample_tick = phi1_rise & (slot == 5'd31);
    assign o_phi1      = phi1;

    assign bus_raw = {i_CS_n, i_RD_n, i_WR_n, i_A0, i_D};
    assign bus_s   = (FULLY_SYNCHRONOUS != 0) ? sync2 : sync1;
    assign {cs_s, rd_s, wr_s, a0_s, d_s} = bus_s;

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sync1 <= 12'hE00;
            sync2 <= 12'hE00;
        end else begin
            sync1 <= bus_raw;
            sync2 <= sync1;
        end
    end

    // Without fast reset the register file has no reset; it is zeroed by the sweep instead.
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            if (FAST_RESET != 0) state <= ST_RUN;
            else                 state <= ST_SWEEP;
            sweep_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_SWEEP && phi1_rise) sweep_addr <= sweep_addr + 8'd1;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == ST_SWEEP && phi1_rise && sweep_addr == 8'hFF) state_nx = ST_RUN;
    end

    assign wr_fall = wstb_q & ~(cs_s | wr_s);
    assign data_wr = wr_fall &  a0_s & (state == ST_RUN);
    assign addr_wr = wr_fall & ~a0_s & (state == ST_RUN);

    always_comb begin
        reg_we = 1'b0;
        reg_wa = addr_q;
        reg_wd = d_s;
        if (state == ST_SWEEP) begin
            reg_we = phi1_rise;
            reg_wa = sweep_addr;
            reg_wd = '0;
        end else if (data_wr) begin
            reg_we = 1'b1;
        end
    end

    generate
        if (FAST_RESET != 0) begin : g_fast_rst
            always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
                if (!i_IC_n) begin
                    for (int unsigned i = 0; i < 256; i++) regs[8'(i)] <= '0;
                end else if (reg_we) begin
                    regs[reg_wa] <= reg_wd;
                end
            end
        end else begin : g_sweep_rst
            always_ff @(posedge i_EMUCLK) begin
                if (reg_we) regs[reg_wa] <= reg_wd;
            end
        end
    endgenerate

    assign na = {regs[8'h10], regs[8'h11][1:0]};
    assign nb = regs[8'h12];

    always_comb begin
        sum_r = '0;
        sum_l = '0;
        kc    = '0;
        tl    = '0;
        rl    = '0;
        inc   = '0;
        amp   = '0;
        val   = '0;
        for (int unsigned ch = 0; ch < 8; ch++) begin
            kc  = regs[8'(32'h28 + ch)][6:0];
            tl  = regs[8'(32'h60 + ch)][6:3];
            rl  = regs[8'(32'h20 + ch)][7:6];
            inc = 16'({4'b0001, kc[3:0]}) << kc[6:4];
            phase_nx[3'(ch)] = keyon[ch] ? phase[3'(ch)] + inc : '0;
            amp = 13'h1FFF >> tl;
            if (!keyon[ch])                val = '0;
            else if (phase_nx[3'(ch)][15]) val = -signed'({2'b00, amp});
            else                           val = signed'({2'b00, amp});
            if (rl[1]) sum_r = sum_r + 19'(val);
            if (rl[0]) sum_l = sum_l + 19'(val);
        end
    end

    assign mix_r     = sat16(sum_r);
    assign mix_l     = sat16(sum_l);
    assign enc_r     = float_enc(mix_r);
    assign enc_l     = float_enc(mix_l);
    assign cur_frame = slot[4] ? frame_l : frame_r;
    assign sh_win    = (slot[3:0] >= 4'd3) && (slot[3:0] <= 4'd12);
    assign busy      = (busy_cnt != '0) | (state == ST_SWEEP);
    assign status    = {busy, 5'b00000, flag_b, flag_a};
    assign o_IRQ_n   = ~(flag_a | flag_b);
    assign o_CT1     = ct[0];
    assign o_CT2     = ct[1];

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            phi1           <= 1'b0;
            slot           <= '0;
            wstb_q         <= 1'b1;
            addr_q         <= '0;
            busy_cnt       <= '0;
            keyon          <= '0;
            for (int unsigned ch = 0; ch < 8; ch++) phase[3'(ch)] <= '0;
            cnt_a          <= '0;
            cnt_b          <= '0;
            presc_b        <= '0;
            tctrl          <= '0;
            flag_a         <= 1'b0;
            flag_b         <= 1'b0;
            ct             <= '0;
            frame_r        <= '0;
            frame_l        <= '0;
            o_SO           <= 1'b0;
            o_SH1          <= 1'b0;
            o_SH2          <= 1'b0;
            o_D            <= '0;
            o_D_OE         <= 1'b0;
            o_EMU_R_SAMPLE <= 1'b0;
            o_EMU_L_SAMPLE <= 1'b0;
            o_EMU_R        <= '0;
            o_EMU_L        <= '0;
            o_EMU_R_EX     <= '0;
            o_EMU_L_EX     <= '0;
        end else begin
            o_EMU_R_SAMPLE <= 1'b0;
            o_EMU_L_SAMPLE <= 1'b0;
            wstb_q         <= cs_s | wr_s;
            o_D_OE         <= ~cs_s & ~rd_s;
            o_D            <= (~cs_s & ~rd_s) ? status : '0;

            if (!i_phiM_PCEN_n) phi1 <= ~phi1;

            if (phi1_rise) begin
                slot <= slot + 5'd1;
                if (busy_cnt != '0) busy_cnt <= busy_cnt - 6'd1;
            end

            if (phi1_fall) begin
                o_SO  <= (slot[3:0] < 4'd13) ? cur_frame[slot[3:0]] : 1'b0;
                o_SH1 <= ~slot[4] & sh_win;
                o_SH2 <=  slot[4] & sh_win;
            end

            if (sample_tick) begin
                for (int unsigned ch = 0; ch < 8; ch++) phase[3'(ch)] <= phase_nx[3'(ch)];
                o_EMU_R        <= mix_r;
                o_EMU_L        <= mix_l;
                o_EMU_R_EX     <= float_dec(enc_r);
                o_EMU_L_EX     <= float_dec(enc_l);
                frame_r        <= enc_r;
                frame_l        <= enc_l;
                o_EMU_R_SAMPLE <= 1'b1;
                o_EMU_L_SAMPLE <= 1'b1;
                presc_b        <= presc_b + 4'd1;
                if (tctrl[0]) begin
                    if (cnt_a == 10'h3FF) begin
                        cnt_a <= na;
                        if (tctrl[2]) flag_a <= 1'b1;
                    end else begin
                        cnt_a <= cnt_a + 10'd1;
                    end
                end
                if (tctrl[1] && presc_b == 4'hF) begin
                    if (cnt_b == 8'hFF) begin
                        cnt_b <= nb;
                        if (tctrl[3]) flag_b <= 1'b1;
                    end else begin
                        cnt_b <= cnt_b + 8'd1;
                    end
                end
            end

            if (addr_wr) addr_q <= d_s;

            // Bus writes come last so a timer load or flag clear wins over a coincident tick.
            if (data_wr) begin
                busy_cnt <= 6'd32;
                case (addr_q)
                    8'h08: keyon[d_s[2:0]] <= |d_s[6:3];
                    8'h14: begin
                        tctrl <= d_s[3:0];
                        if (d_s[0] && !tctrl[0]) cnt_a <= na;
                        if (d_s[1] && !tctrl[1]) cnt_b <= nb;
                        if (d_s[4]) flag_a <= 1'b0;
                        if (d_s[5]) flag_b <= 1'b0;
                    end
                    8'h1B: ct <= d_s[7:6];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ikaopm_core.sv
// Directed bench for ikaopm_core: reset state, phi1 divider, tone/mix/float output,
// key-off, stereo routing, timer A IRQ, CT bits, busy flag and mid-frame reset.
module tb_ikaopm_core;

    logic               clk = 1'b0;
    logic               ic_n = 1'b0;
    logic               pcen_n = 1'b1;
    logic               cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [7:0]         d_in = '0;
    logic               o_phi1;
    logic [7:0]         o_D;
    logic               o_D_OE, o_CT1, o_CT2, o_IRQ_n, o_SH1, o_SH2, o_SO;
    logic               o_EMU_R_SAMPLE, o_EMU_L_SAMPLE;
    logic signed [15:0] o_EMU_R_EX, o_EMU_L_EX, o_EMU_R, o_EMU_L;

    int tests = 0;
    int fails = 0;
    int rises, bad_gap, last_rise, cyc;
    logic prev_phi1;
    logic [7:0]  st;
    logic        oe;
    logic [12:0] so_bits, sh_bits;

    always #5 clk = ~clk;

    ikaopm_core #(.FULLY_SYNCHRONOUS(1), .FAST_RESET(1)) dut (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n), .o_phi1(o_phi1),
        .i_CS_n(cs_n), .i_RD_n(rd_n), .i_WR_n(wr_n), .i_A0(a0), .i_D(d_in),
        .o_D(o_D), .o_D_OE(o_D_OE), .o_CT1(o_CT1), .o_CT2(o_CT2), .o_IRQ_n(o_IRQ_n),
        .o_SH1(o_SH1), .o_SH2(o_SH2), .o_SO(o_SO),
        .o_EMU_R_SAMPLE(o_EMU_R_SAMPLE), .o_EMU_L_SAMPLE(o_EMU_L_SAMPLE),
        .o_EMU_R_EX(o_EMU_R_EX), .o_EMU_L_EX(o_EMU_L_EX),
        .o_EMU_R(o_EMU_R), .o_EMU_L(o_EMU_L)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic addr_bit, input logic [7:0] data);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = addr_bit; d_in = data;
        repeat (4) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [7:0] data);
        bus_write(1'b0, addr);
        bus_write(1'b1, data);
    endtask

    task automatic read_status(output logic [7:0] d, output logic en);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0;
        repeat (4) @(negedge clk);
        d = o_D; en = o_D_OE;
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_sample();
        int n = 0;
        @(negedge clk);
        while (!o_EMU_R_SAMPLE && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $error("FAIL sample_timeout: observed no sample pulse within %0d cycles, required one", n);
        end
    endtask

    // Captures SO/SH1 at the 13 phi1 rises following a sample pulse (sub-slots 0..12 of R half).
    task automatic capture_r(output logic [12:0] sob, output logic [12:0] shb);
        int n;
        sob = '0; shb = '0;
        for (int k = 0; k < 13; k++) begin
            n = 0;
            while (o_phi1 && n < 10) begin @(negedge clk); n++; end
            while (!o_phi1 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) begin
                tests++;
                fails++;
                $error("FAIL phi1_timeout: observed no phi1 rise, required one");
            end
            sob[k] = o_SO;
            shb[k] = o_SH1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_phi1", {15'd0, o_phi1}, 16'd0);
        check("rst_ser", {13'd0, o_SO, o_SH1, o_SH2}, 16'd0);
        check("rst_irq", {15'd0, o_IRQ_n}, 16'd1);
        check("rst_dbus", {7'd0, o_D_OE, o_D}, 16'd0);
        check("rst_ct", {14'd0, o_CT2, o_CT1}, 16'd0);
        check("rst_emu_r", o_EMU_R, 16'd0);
        check("rst_emu_lex", o_EMU_L_EX, 16'd0);
        ic_n = 1'b1;

        // 100 phiM enables, one every other EMUCLK: 50 phi1 rises, 4 EMUCLK apart.
        rises = 0; bad_gap = 0; last_rise = -1; cyc = 0; prev_phi1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            pcen_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            cyc++;
            if (o_phi1 && !prev_phi1) begin
                if (last_rise >= 0 && cyc - last_rise != 4) bad_gap++;
                last_rise = cyc;
                rises++;
            end
            prev_phi1 = o_phi1;
        end
        check("phi1_rises", 16'(rises), 16'd50);
        check("phi1_period", 16'(bad_gap), 16'd0);
        pcen_n = 1'b0;

        read_status(st, oe);
        check("status_idle", {7'd0, oe, st}, 16'h0100);

        // ch0: KC 0x42 -> inc 288, TL 21 -> amp 2047, both sides on.
        reg_write(8'h28, 8'h42);
        reg_write(8'h60, 8'd21);
        reg_write(8'h20, 8'hFC);
        reg_write(8'h08, 8'h18);
        wait_sample();
        check("tone_r", o_EMU_R, 16'd2047);
        check("tone_l", o_EMU_L, 16'd2047);
        check("tone_rex", o_EMU_R_EX, 16'd2044);
        check("tone_lex", o_EMU_L_EX, 16'd2044);
        capture_r(so_bits, sh_bits);
        check("frame_pos", {3'd0, so_bits}, 16'h0FFF);
        check("sh1_window", {3'd0, sh_bits}, 16'h1FF8);

        for (int i = 2; i <= 113; i++) wait_sample();
        check("pre_flip_r", o_EMU_R, 16'd2047);
        wait_sample();
        check("flip_r", o_EMU_R, 16'(-2047));
        check("flip_l", o_EMU_L, 16'(-2047));
        check("flip_rex", o_EMU_R_EX, 16'(-2044));

        reg_write(8'h08, 8'h00);
        wait_sample();
        check("keyoff_r", o_EMU_R, 16'd0);
        check("keyoff_l", o_EMU_L, 16'd0);
        check("keyoff_rex", o_EMU_R_EX, 16'd0);
        capture_r(so_bits, sh_bits);
        check("frame_zero", {3'd0, so_bits}, 16'h0600);

        reg_write(8'h08, 8'h18);
        wait_sample();
        check("rekey_phase", o_EMU_R, 16'd2047);

        reg_write(8'h20, 8'h80);
        wait_sample();
        check("ronly_r", o_EMU_R, 16'd2047);
        check("ronly_l", o_EMU_L, 16'd0);
        check("ronly_lex", o_EMU_L_EX, 16'd0);

        reg_write(8'h10, 8'hFF);
        reg_write(8'h11, 8'h03);
        reg_write(8'h14, 8'h05);
        wait_sample();
        check("timera_irq", {15'd0, o_IRQ_n}, 16'd0);
        repeat (80) @(negedge clk);
        read_status(st, oe);
        check("timera_status", {7'd0, oe, st}, 16'h0101);
        reg_write(8'h14, 8'h10);
        check("timera_clear", {15'd0, o_IRQ_n}, 16'd1);

        reg_write(8'h1B, 8'hC0);
        read_status(st, oe);
        check("busy_set", {8'd0, st}, 16'h0080);
        check("ct_bits", {14'd0, o_CT2, o_CT1}, 16'd3);
        repeat (80) @(negedge clk);
        read_status(st, oe);
        check("busy_clear", {8'd0, st}, 16'h0000);

        // Reset in the middle of a frame with ch0 sounding on R.
        repeat (37) @(negedge clk);
        ic_n = 1'b0;
        #1;
        check("midrst_r", o_EMU_R, 16'd0);
        check("midrst_ct", {14'd0, o_CT2, o_CT1}, 16'd0);
        check("midrst_phi1_ser", {12'd0, o_phi1, o_SO, o_SH1, o_SH2}, 16'd0);
        check("midrst_irq", {15'd0, o_IRQ_n}, 16'd1);
        repeat (3) @(negedge clk);
        ic_n = 1'b1;
        wait_sample();
        check("post_rst_r", o_EMU_R, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
